// File: rtl/significand_mult_seq_pkg.sv
// ============================================================================
// Module : significand_mult_seq_pkg
// Brief  : FSM encodings and per-format fraction widths for the significand
//          multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package significand_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_MAN_W_FP16 = 10;
    localparam int c_MAN_W_BF16 = 7;
    localparam int c_MAN_W_FP32 = 23;

endpackage

`default_nettype wire

// File: rtl/significand_mult_seq_rne_rounder.sv
// ============================================================================
// Module : rne_rounder
// Brief  : Normalises a (2*MAN_W+2)-bit significand product and rounds it to
//          nearest-even; purely combinational.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rne_rounder #(
    parameter int MAN_W = 10
) (
    input  logic [2*MAN_W+1:0] product,
    output logic [MAN_W-1:0]   result,
    output logic               significand_msb,
    output logic               round_carry,
    output logic               inexact
);

    localparam int c_PW = 2*MAN_W + 2;

    logic [MAN_W-1:0] w_frac;
    logic             w_guard;
    logic             w_sticky;
    logic             w_inc;

    always_comb begin
        w_frac   = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        // A product >= 2.0 keeps one more bit above the binary point.
        if (product[c_PW-1]) begin
            w_frac   = product[c_PW-2:MAN_W+1];
            w_guard  = product[MAN_W];
            w_sticky = |product[MAN_W-1:0];
        end else begin
            w_frac   = product[c_PW-3:MAN_W];
            w_guard  = product[MAN_W-1];
            w_sticky = |product[MAN_W-2:0];
        end
    end

    assign w_inc           = w_guard & (w_sticky | w_frac[0]);
    assign result          = w_frac + {{(MAN_W-1){1'b0}}, w_inc};
    assign round_carry     = w_inc & (&w_frac);
    assign inexact         = w_guard | w_sticky;
    assign significand_msb = product[c_PW-1];

endmodule

`default_nettype wire

// File: rtl/significand_mult_seq.sv
// ============================================================================
// Module : significand_mult_seq
// Brief  : Sequential radix-2 shift-add significand multiplier with RNE
//          rounding and valid/ready handshakes. Define SIG_MULT_EARLY_EXIT_EN
//          to leave the multiply loop once the remaining multiplier is zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module significand_mult_seq
    import significand_mult_seq_pkg::*;
#(
    parameter int MAN_W = 10,
    parameter int CNT_W = $clog2(MAN_W+2)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    input  logic             hidden_a,
    input  logic             hidden_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] result,
    output logic             significand_msb,
    output logic             round_carry,
    output logic             inexact
);

    localparam int c_PW = 2*MAN_W + 2;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_PW-1:0]  r_a;
    logic [c_PW-1:0]  r_acc;
    logic [MAN_W:0]   r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [MAN_W-1:0] r_result;
    logic             r_msb;
    logic             r_round_carry;
    logic             r_inexact;

    logic [MAN_W:0]   w_b_shift;
    logic             w_accept;
    logic             w_mul_last;
    logic             w_handshake;
    logic [MAN_W-1:0] w_rnd_result;
    logic             w_rnd_msb;
    logic             w_rnd_carry;
    logic             w_rnd_inexact;

    assign w_b_shift   = r_b >> 1;
    assign w_accept    = in_valid & (r_state == ST_IDLE);
    assign w_handshake = r_out_valid & out_ready;

`ifdef SIG_MULT_EARLY_EXIT_EN
    // Once the multiplier is exhausted the remaining iterations add nothing.
    assign w_mul_last = (r_cnt == CNT_W'(MAN_W)) | (w_b_shift == '0);
`else
    assign w_mul_last = (r_cnt == CNT_W'(MAN_W));
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)    w_state_nxt = ST_MUL;
            ST_MUL:   if (w_mul_last)  w_state_nxt = ST_ROUND;
            ST_ROUND:                  w_state_nxt = ST_DONE;
            ST_DONE:  if (w_handshake) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= {{(c_PW-MAN_W-1){1'b0}}, hidden_a, man_a};
            r_b   <= {hidden_b, man_b};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_MUL) begin
            if (r_b[0]) begin
                r_acc <= r_acc + r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= w_b_shift;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    rne_rounder #(
        .MAN_W (MAN_W)
    ) u_rne_rounder (
        .product         (r_acc),
        .result          (w_rnd_result),
        .significand_msb (w_rnd_msb),
        .round_carry     (w_rnd_carry),
        .inexact         (w_rnd_inexact)
    );

    // out_valid is registered from DONE so the result registers settle a
    // full cycle before being presented.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_result      <= '0;
            r_msb         <= 1'b0;
            r_round_carry <= 1'b0;
            r_inexact     <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            if (r_state == ST_ROUND) begin
                r_result      <= w_rnd_result;
                r_msb         <= w_rnd_msb;
                r_round_carry <= w_rnd_carry;
                r_inexact     <= w_rnd_inexact;
            end
            r_out_valid <= (r_state == ST_DONE) & ~w_handshake;
        end
    end

    assign in_ready        = (r_state == ST_IDLE);
    assign out_valid       = r_out_valid;
    assign result          = r_result;
    assign significand_msb = r_msb;
    assign round_carry     = r_round_carry;
    assign inexact         = r_inexact;

endmodule

`default_nettype wire

// File: tb/tb_significand_mult_seq.sv
// ============================================================================
// Module : tb_significand_mult_seq
// Brief  : Randomised self-checking bench for significand_mult_seq (MAN_W=10)
//          against an arithmetic rounding model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_significand_mult_seq;

    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset_b = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] man_a = '0;
    logic [M-1:0] man_b = '0;
    logic         hidden_a = 1'b0;
    logic         hidden_b = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [M-1:0] result;
    logic         significand_msb;
    logic         round_carry;
    logic         inexact;

    int n_vec = 0;
    int n_err = 0;

    significand_mult_seq #(.MAN_W(M)) dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .man_a           (man_a),
        .man_b           (man_b),
        .hidden_a        (hidden_a),
        .hidden_b        (hidden_b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result),
        .significand_msb (significand_msb),
        .round_carry     (round_carry),
        .inexact         (inexact)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Real-valued product rounded by comparing the discarded remainder to one half.
    task automatic ref_model(input bit ha, input logic [M-1:0] ma, input bit hb, input logic [M-1:0] mb,
                             output logic [M-1:0] e_res, output bit e_msb, output bit e_rc,
                             output bit e_inx, output int e_lat);
        longint unsigned p, frac, rem, half, sum;
        int sh, nbits;
        longint unsigned bv;
        p     = (longint'(ha) * 1024 + longint'(ma)) * (longint'(hb) * 1024 + longint'(mb));
        e_msb = (p >= 64'd2097152);
        sh    = e_msb ? M + 1 : M;
        frac  = (p >> sh) % 1024;
        rem   = p % (64'd1 << sh);
        half  = 64'd1 << (sh - 1);
        sum   = frac + (((rem > half) || (rem == half && frac % 2 == 1)) ? 1 : 0);
        e_res = M'(sum % 1024);
        e_rc  = (sum == 1024);
        e_inx = (rem != 0);
`ifdef SIG_MULT_EARLY_EXIT_EN
        bv = longint'(hb) * 1024 + longint'(mb);
        nbits = 0;
        while (bv != 0) begin
            nbits++;
            bv = bv / 2;
        end
        if (nbits == 0) nbits = 1;
        e_lat = nbits + 2;
`else
        bv = 0;
        nbits = 0;
        e_lat = M + 3;
`endif
    endtask

    task automatic run_op(input bit ha, input logic [M-1:0] ma, input bit hb, input logic [M-1:0] mb,
                          input int stall);
        logic [M-1:0] e_res;
        bit e_msb, e_rc, e_inx;
        int e_lat, lat;
        ref_model(ha, ma, hb, mb, e_res, e_msb, e_rc, e_inx, e_lat);
        @(negedge clk);
        chk_eq("in_ready_idle", in_ready, 1);
        hidden_a = ha; man_a = ma; hidden_b = hb; man_b = mb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_eq("latency", lat, e_lat);
        chk_eq("result", result, e_res);
        chk_eq("msb", significand_msb, e_msb);
        chk_eq("round_carry", round_carry, e_rc);
        chk_eq("inexact", inexact, e_inx);
        chk_eq("in_ready_busy", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            man_a = M'($urandom);
            hidden_a = 1'b1;
            @(posedge clk); #1;
            chk_eq("stall_valid", out_valid, 1);
            chk_eq("stall_result", result, e_res);
            chk_eq("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_eq("valid_drop", out_valid, 0);
        chk_eq("in_ready_back", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", in_ready, 1);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_result", result, 0);
        chk_eq("rst_flags", {significand_msb, round_carry, inexact}, 0);
        @(negedge clk);
        reset_b = 1'b1;

        run_op(1'b1, 10'h000, 1'b1, 10'h000, 0);
        run_op(1'b1, 10'h200, 1'b1, 10'h200, 0);
        run_op(1'b1, 10'h3FF, 1'b1, 10'h3FF, 0);
        run_op(1'b1, 10'h001, 1'b1, 10'h200, 0);
        run_op(1'b0, 10'h000, 1'b0, 10'h000, 0);
        run_op(1'b1, 10'h155, 1'b1, 10'h2AA, 5);
`ifdef SIG_MULT_EARLY_EXIT_EN
        run_op(1'b1, 10'h123, 1'b1, 10'h000, 0);
`endif

        // Abort mid-multiply, then confirm a fresh operation is clean.
        @(negedge clk);
        hidden_a = 1'b1; man_a = 10'h3FF; hidden_b = 1'b1; man_b = 10'h3FF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        chk_eq("abort_out_valid", out_valid, 0);
        chk_eq("abort_in_ready", in_ready, 1);
        chk_eq("abort_result", result, 0);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk_eq("abort_no_valid", out_valid, 0);
        end
        run_op(1'b1, 10'h200, 1'b1, 10'h200, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(($urandom_range(0, 7) != 0), M'($urandom), ($urandom_range(0, 7) != 0),
                   M'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
